sync_burst_sram_model: RTL and testbench

Parametrised, synthesizable behavioural model of a single-port synchronous burst SRAM, the drop-in successor to the fixed x18 flow-through part model. It adds configurable address and data width, byte-lane count, a flow-through/pipelined output selection, a synchronous reset of control state and a ZZ recovery window. Vector-driven benches instantiate it in place of the vendor model; the pin-level protocol is ADSP/ADSC/ADV with three chip enables.

---
 rtl/sync_burst_sram_model.sv | 149 ++++++++++++++
 tb/tb_sync_burst_sram_model.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sync_burst_sram_model.sv
// Synchronous burst SRAM model (ADSP/ADSC/ADV, three chip enables) with a
// selectable flow-through or pipelined read path and ZZ sleep with a recovery window.
module sync_burst_sram_model #(
    parameter int ADDR_W    = 16,
    parameter int BYTES     = 2,
    parameter int BYTE_W    = 9,
    parameter int PIPELINED = 0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      ZZ,
    input  logic                      MODE,
    input  logic [ADDR_W-1:0]         ADDR,
    input  logic                      GW_N,
    input  logic                      BWE_N,
    input  logic [BYTES-1:0]          BW_N,
    input  logic                      CE1_N,
    input  logic                      CE2,
    input  logic                      CE3_N,
    input  logic                      ADSP_N,
    input  logic                      ADSC_N,
    input  logic                      ADV_N,
    input  logic                      OE_N,
    inout  wire  [BYTES*BYTE_W-1:0]   DQ
);
    localparam int DW        = BYTES * BYTE_W;
    localparam int STAGES    = (PIPELINED != 0) ? 1 : 0;
    localparam int REC_EDGES = 2;

    typedef enum logic [1:0] {ST_RUN, ST_SLEEP, ST_RECOVER} state_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_DESEL, CMD_READ, CMD_WRITE} cmd_t;

    state_t            state;
    logic [1:0]        rec_cnt;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        acc_lo;
    logic [ADDR_W-1:0] acc_addr;
    cmd_t              cmd, rw_cmd;
    logic              sel, wr, active, load;
    logic              wr_en, rd_en;
    logic [BYTES-1:0]  lane_mask;
    logic [STAGES:0]   vld_pipe;
    logic [DW-1:0]     rd_word, dout;
    logic              dq_oe;

    assign sel       = !CE1_N && CE2 && !CE3_N;
    assign lane_mask = !GW_N ? '1 : (!BWE_N ? ~BW_N : '0);
    assign wr        = |lane_mask;
    assign rw_cmd    = wr ? CMD_WRITE : CMD_READ;
    assign active    = !RST && (state == ST_RUN) && !ZZ;

    // First match wins; an ADSP qualified by CE1_N=1 falls through to ADSC.
    always_comb begin
        cmd   = CMD_NONE;
        load  = 1'b0;
        cnt_d = cnt_q;
        if (active) begin
            if (!ADSP_N && !CE1_N) begin
                if (sel) begin
                    load  = 1'b1;
                    cnt_d = 2'd0;
                    cmd   = CMD_READ;
                end else begin
                    cmd = CMD_DESEL;
                end
            end else if (!ADSC_N) begin
                if (sel) begin
                    load  = 1'b1;
                    cnt_d = 2'd0;
                    cmd   = rw_cmd;
                end else begin
                    cmd = CMD_DESEL;
                end
            end else if (!ADV_N) begin
                cnt_d = cnt_q + 2'd1;
                cmd   = rw_cmd;
            end else begin
                cmd = rw_cmd;
            end
        end
    end

    assign base_d   = load ? ADDR : base_q;
    assign acc_lo   = MODE ? (base_d[1:0] ^ cnt_d) : (base_d[1:0] + cnt_d);
    assign acc_addr = {base_d[ADDR_W-1:2], acc_lo};
    assign wr_en    = (cmd == CMD_WRITE);
    assign rd_en    = (cmd == CMD_READ);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_RUN;
            rec_cnt  <= '0;
            base_q   <= '0;
            cnt_q    <= '0;
            vld_pipe <= '0;
        end else begin
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            vld_pipe[0] <= rd_en;
            for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
            case (state)
                ST_RUN: if (ZZ) state <= ST_SLEEP;
                ST_SLEEP: begin
                    if (!ZZ) begin
                        state   <= ST_RECOVER;
                        rec_cnt <= '0;
                    end
                end
                ST_RECOVER: begin
                    if (ZZ) begin
                        state <= ST_SLEEP;
                    end else if (rec_cnt == 2'(REC_EDGES - 1)) begin
                        state   <= ST_RUN;
                        rec_cnt <= '0;
                    end else begin
                        rec_cnt <= rec_cnt + 2'd1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Each byte lane owns its own storage so partial writes touch only that lane.
    for (genvar l = 0; l < BYTES; l++) begin : g_lane
        logic [BYTE_W-1:0] mem [2**ADDR_W];
        logic [BYTE_W-1:0] rd_q;
        always_ff @(posedge CLK) begin
            if (wr_en && lane_mask[l]) mem[acc_addr] <= DQ[l*BYTE_W +: BYTE_W];
            if (rd_en) rd_q <= mem[acc_addr];
        end
        assign rd_word[l*BYTE_W +: BYTE_W] = rd_q;
    end

    if (STAGES == 1) begin : g_pipe
        logic [DW-1:0] dat_q;
        always_ff @(posedge CLK) begin
            if (vld_pipe[0]) dat_q <= rd_word;
        end
        assign dout = dat_q;
    end else begin : g_flow
        assign dout = rd_word;
    end

    assign dq_oe = vld_pipe[STAGES] && !OE_N && (state != ST_SLEEP);
    assign DQ    = dq_oe ? dout : 'z;

endmodule

// File: tb/tb_sync_burst_sram_model.sv
// Directed bench: flow-through and pipelined instances share one stimulus stream;
// the pipelined bus is expected to show the flow-through value one edge later.
module tb_sync_burst_sram_model;
    localparam logic [17:0] HIZ = 18'h3FFFF;   // undriven bus floats high via tri1

    logic        CLK = 1'b0;
    logic        RST, ZZ, MODE, GW_N, BWE_N, CE1_N, CE2, CE3_N;
    logic        ADSP_N, ADSC_N, ADV_N, OE_N;
    logic [15:0] ADDR;
    logic [1:0]  BW_N;
    logic        drv_en;
    logic [17:0] drv_val;
    logic [17:0] prev;
    tri1  [17:0] dq_f;
    tri1  [17:0] dq_p;
    int          total = 0;
    int          bad   = 0;

    always #5 CLK = ~CLK;

    assign dq_f = drv_en ? drv_val : 'z;
    assign dq_p = drv_en ? drv_val : 'z;

    sync_burst_sram_model #(.PIPELINED(0)) u_ft (
        .CLK(CLK), .RST(RST), .ZZ(ZZ), .MODE(MODE), .ADDR(ADDR),
        .GW_N(GW_N), .BWE_N(BWE_N), .BW_N(BW_N),
        .CE1_N(CE1_N), .CE2(CE2), .CE3_N(CE3_N),
        .ADSP_N(ADSP_N), .ADSC_N(ADSC_N), .ADV_N(ADV_N), .OE_N(OE_N), .DQ(dq_f));

    sync_burst_sram_model #(.PIPELINED(1)) u_pl (
        .CLK(CLK), .RST(RST), .ZZ(ZZ), .MODE(MODE), .ADDR(ADDR),
        .GW_N(GW_N), .BWE_N(BWE_N), .BW_N(BW_N),
        .CE1_N(CE1_N), .CE2(CE2), .CE3_N(CE3_N),
        .ADSP_N(ADSP_N), .ADSC_N(ADSC_N), .ADV_N(ADV_N), .OE_N(OE_N), .DQ(dq_p));

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    task automatic step2(input string tag, input logic [17:0] ef, input logic [17:0] ep);
        @(posedge CLK);
        #1 drv_en = 1'b0;
        #1;
        check({tag, "/ft"}, dq_f, ef);
        check({tag, "/pl"}, dq_p, ep);
        prev = ef;
    endtask

    task automatic step(input string tag, input logic [17:0] ef);
        step2(tag, ef, prev);
    endtask

    // Idle cycle is an explicit deselect so no stray suspend-reads occur.
    task automatic idle();
        ADSP_N = 1'b1; ADSC_N = 1'b0; ADV_N = 1'b1;
        CE1_N = 1'b0; CE2 = 1'b0; CE3_N = 1'b0;
        GW_N = 1'b1; BWE_N = 1'b1; BW_N = 2'b11;
        drv_en = 1'b0; drv_val = '0;
    endtask

    task automatic adsc_wr(input logic [15:0] a, input logic [17:0] d);
        idle(); CE2 = 1'b1; ADDR = a; GW_N = 1'b0; drv_en = 1'b1; drv_val = d;
    endtask

    task automatic adsp_rd(input logic [15:0] a);
        idle(); ADSC_N = 1'b1; ADSP_N = 1'b0; CE2 = 1'b1; ADDR = a;
    endtask

    task automatic adv(input logic w, input logic [17:0] d);
        idle(); ADSC_N = 1'b1; ADV_N = 1'b0; CE2 = 1'b1; ADDR = 16'h00FF;
        GW_N = !w; drv_en = w; drv_val = d;
    endtask

    task automatic susp();
        idle(); ADSC_N = 1'b1; CE2 = 1'b1; ADDR = 16'h00FF;
    endtask

    initial begin
        RST = 1'b1; ZZ = 1'b0; MODE = 1'b0; OE_N = 1'b0; ADDR = '0; prev = HIZ;
        idle();
        step2("reset", HIZ, HIZ);
        step2("reset", HIZ, HIZ);
        RST = 1'b0;

        // single write / read, OE_N gating
        adsc_wr(16'h0004, 18'h2A5A5); step("wr4", HIZ);
        adsp_rd(16'h0004);            step("rd4", 18'h2A5A5);
        OE_N = 1'b1; #1; check("oe_off", dq_f, HIZ);
        OE_N = 1'b0; #1; check("oe_on", dq_f, 18'h2A5A5);
        idle(); step("gap", HIZ);
        idle(); step("gap", HIZ);

        // linear burst writes then reads, with ADSP ignored when CE1_N=1
        adsc_wr(16'h0006, 18'h1); step("lin_w6", HIZ);
        adv(1'b1, 18'h2);         step("lin_w7", HIZ);
        adv(1'b1, 18'h3);         step("lin_w4", HIZ);
        adv(1'b1, 18'h4);         step("lin_w5", HIZ);
        adsp_rd(16'h0006);        step("lin_r6", 18'h1);
        adv(1'b0, '0); ADSP_N = 1'b0; CE1_N = 1'b1; ADDR = 16'h0020;
                                  step("adsp_ce1_ign", 18'h2);
        adv(1'b0, '0);            step("lin_r4", 18'h3);
        adv(1'b0, '0);            step("lin_r5", 18'h4);
        adv(1'b0, '0);            step("lin_wrap", 18'h1);
        idle(); step("gap", HIZ);
        idle(); step("gap", HIZ);

        // interleaved bursts from base 6 and base 5, with a suspend
        MODE = 1'b1;
        adsp_rd(16'h0006); step("il6_r6", 18'h1);
        adv(1'b0, '0);     step("il6_r7", 18'h2);
        adv(1'b0, '0);     step("il6_r4", 18'h3);
        adv(1'b0, '0);     step("il6_r5", 18'h4);
        adsp_rd(16'h0005); step("il5_r5", 18'h4);
        adv(1'b0, '0);     step("il5_r4", 18'h3);
        susp();            step("il5_susp", 18'h3);
        adv(1'b0, '0);     step("il5_r7", 18'h2);
        adv(1'b0, '0);     step("il5_r6", 18'h1);
        idle(); step("gap", HIZ);
        idle(); step("gap", HIZ);
        MODE = 1'b0;

        // byte-lane writes; ADSC with no enabled lane is a read
        adsc_wr(16'h0010, 18'h3FFFF); step("bw_full", HIZ);
        adsc_wr(16'h0010, 18'h00000); GW_N = 1'b1; BWE_N = 1'b0; BW_N = 2'b10;
                                      step("bw_lane0", HIZ);
        adsc_wr(16'h0010, 18'h00000); GW_N = 1'b1; BWE_N = 1'b0; BW_N = 2'b11; drv_en = 1'b0;
                                      step("bw_none_rd", 18'h3FE00);
        idle(); step("gap", HIZ);
        idle(); step("gap", HIZ);
        adsc_wr(16'h0010, 18'h15600); GW_N = 1'b1; BWE_N = 1'b0; BW_N = 2'b01;
                                      step("bw_lane1", HIZ);
        adsp_rd(16'h0010);            step("bw_rd", 18'h15600);
        idle(); step("gap", HIZ);
        idle(); step("gap", HIZ);

        // ZZ sleep and recovery window
        adsc_wr(16'h0020, 18'h12345); step("zz_pre_w", HIZ);
        adsp_rd(16'h0020);            step("zz_pre_r", 18'h12345);
        ZZ = 1'b1; idle();            step2("zz0", HIZ, HIZ);
        adsc_wr(16'h0020, 18'h0BEEF); step("zz1", HIZ);
        adsc_wr(16'h0020, 18'h0BEEF); step("zz2", HIZ);
        ZZ = 1'b0;
        adsc_wr(16'h0020, 18'h0BEEF); step("rec0", HIZ);
        adsc_wr(16'h0020, 18'h0BEEF); step("rec1", HIZ);
        adsp_rd(16'h0020);            step("rec2", HIZ);
        adsp_rd(16'h0020);            step("wake", 18'h12345);
        idle(); step("gap", HIZ);
        idle(); step("gap", HIZ);

        // reset mid-burst
        adsc_wr(16'h0000, 18'h0AAAA); step("rst_w0", HIZ);
        adv(1'b1, 18'h15555);         step("rst_w1", HIZ);
        adsp_rd(16'h0004);            step("rst_r4", 18'h3);
        adv(1'b0, '0);                step("rst_r5", 18'h4);
        adv(1'b0, '0); RST = 1'b1;    step2("rst_mid", HIZ, HIZ);
        RST = 1'b0;
        susp();                       step("rst_susp0", 18'h0AAAA);
        adv(1'b0, '0);                step("rst_adv1", 18'h15555);
        adsp_rd(16'h0004);            step("rst_keep4", 18'h3);
        idle(); step("gap", HIZ);
        idle(); step("gap", HIZ);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
